arith_share_arb: RTL and testbench
==================================

ARITH_SHARE_ARB -- requirements
Module: arith_share_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one arithmetic unit, range 2..8.
REQ-002 Parameter MAX_OUTST, default 8: maximum issued-but-unreturned operations, power of two, range 2..32.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port clk_en  in  1  global enable; when 0, all registers hold their values.
REQ-006 Port req_val  in  N_REQ  per-requester operation valid.
REQ-007 Port req_rdy  out  N_REQ  per-requester grant, one-hot or zero.
REQ-008 Port req_op_a, req_op_b  in  N_REQ x C_ARITH_WORD_LEN  per-requester operands.
REQ-009 Port req_sel  in  N_REQ  per-requester operation, 0 = add, 1 = mult.
REQ-010 Port unit_op_a, unit_op_b  out  C_ARITH_WORD_LEN  operands to the shared unit, registered.
REQ-011 Port unit_op_val, unit_sel  out  1 each  issue strobe and operation select to the unit, registered.
REQ-012 Port unit_res  in  C_ARITH_WORD_LEN, and unit_res_val  in  1: in-order result from the unit.
REQ-013 Port rsp_data  out  C_ARITH_WORD_LEN  result routed back, registered.
REQ-014 Port rsp_val  out  N_REQ  one-hot strobe naming the requester that owns rsp_data.
REQ-015 Port err_ovf  out  1  sticky flag: result arrived with no outstanding tag.

Function
REQ-016 A transfer occurs on requester i when req_val[i] and req_rdy[i] are both 1 in the same cycle with clk_en = 1.
REQ-017 req_rdy is combinational from req_val, the round-robin pointer and the outstanding count; at most one bit is high per cycle.
REQ-018 Grant order: round-robin; search starts at index (last_grant+1) mod N_REQ; last_grant resets to N_REQ-1, so requester 0 has first priority.
REQ-019 last_grant updates only on a transfer.
REQ-020 No grant is issued when the outstanding count equals MAX_OUTST, unless a result returns in the same cycle.
REQ-021 On a transfer, the granted operands and operation are registered to the unit_* ports with unit_op_val = 1 in the next cycle (issue latency 1); otherwise unit_op_val = 0 and the operand registers hold.
REQ-022 The granted index is pushed into an internal tag FIFO (depth MAX_OUTST) on each transfer.
REQ-023 On unit_res_val = 1, the tag FIFO is popped; rsp_data = unit_res and rsp_val = onehot(tag) in the next cycle; otherwise rsp_val = 0.
REQ-024 A simultaneous push and pop leaves the count unchanged and is legal at count = MAX_OUTST (full) and at count = 0 (empty; the pushed tag is not popped in that cycle).
REQ-025 unit_res_val = 1 with the FIFO empty sets err_ovf, drives no rsp_val and leaves the count at 0.
REQ-026 FIFO pointers wrap modulo MAX_OUTST.
REQ-027 Responses carry no backpressure; a requester must accept rsp_val.
REQ-028 With clk_en = 0, req_rdy = 0 and no state changes; unit_res_val is ignored, because the unit is frozen by the same enable.

Reset
REQ-029 With rst_n = 0 at a clock edge: unit_op_val = 0, rsp_val = 0, err_ovf = 0, count = 0, FIFO pointers = 0, last_grant = N_REQ-1, unit_op_a/b = 0, unit_sel = 0, rsp_data = 0.
REQ-030 Reset takes effect regardless of clk_en; reset during outstanding operations discards all tags, and later unit results set err_ovf.

Structure
REQ-031 C_ARITH_WORD_LEN comes from arith_pckg; new constants C_ARB_N_REQ_MAX = 8 and C_ARB_MAX_OUTST_MAX = 32 are added to arith_pckg.
REQ-032 The round-robin priority search is a sub-module rr_arb_core (inputs: request vector, pointer, enable; output: one-hot grant); the tag FIFO stays inline.

Verification
REQ-033 Single requester, req 0 add with a = 3, b = 5, model unit latency 2 -> unit_op_val at cycle +1, rsp_val = 0001 with rsp_data = 8 at cycle +4.
REQ-034 All four requesters held valid for 8 cycles -> grants follow 0,1,2,3,0,1,2,3, and each requester receives exactly two rsp_val pulses in issue order.
REQ-035 Unit stalled (no results), MAX_OUTST = 8, constant requests -> 8 grants then req_rdy = 0; the first result returned reopens exactly one grant in that same cycle.
REQ-036 Inject unit_res_val with the FIFO empty -> err_ovf = 1 and held, rsp_val = 0, count remains 0.
REQ-037 clk_en = 0 for 3 cycles mid-stream -> no grants, and all outputs hold; on clk_en = 1, the sequence resumes with no lost or duplicated tags.
REQ-038 rst_n = 0 with 5 operations outstanding -> all outputs at reset values the next cycle, the next grant goes to requester 0, and the stale results set err_ovf.

Source files
------------

// File: rtl/arith_pckg.sv
// Shared constants for the arithmetic unit and the logic that feeds it.
package arith_pckg;

  localparam int C_ARITH_WORD_LEN    = 32;
  localparam int C_ARB_N_REQ_MAX     = 8;
  localparam int C_ARB_MAX_OUTST_MAX = 32;

endpackage

// File: rtl/rr_arb_core.sv
// Round-robin priority search: scans from (ptr+1) mod N and grants the first
// active request, one-hot or zero.
module rr_arb_core #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_share_arb.sv
// Shares one in-order arithmetic unit between N_REQ requesters; a tag FIFO
// remembers who issued each operation so results are routed back in order.
module arith_share_arb
  import arith_pckg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clk_en,
  input  logic [N_REQ-1:0]                        req_val,
  output logic [N_REQ-1:0]                        req_rdy,
  input  logic [N_REQ-1:0][C_ARITH_WORD_LEN-1:0]  req_op_a,
  input  logic [N_REQ-1:0][C_ARITH_WORD_LEN-1:0]  req_op_b,
  input  logic [N_REQ-1:0]                        req_sel,
  output logic [C_ARITH_WORD_LEN-1:0]             unit_op_a,
  output logic [C_ARITH_WORD_LEN-1:0]             unit_op_b,
  output logic                                    unit_op_val,
  output logic                                    unit_sel,
  input  logic [C_ARITH_WORD_LEN-1:0]             unit_res,
  input  logic                                    unit_res_val,
  output logic [C_ARITH_WORD_LEN-1:0]             rsp_data,
  output logic [N_REQ-1:0]                        rsp_val,
  output logic                                    err_ovf
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int PTRW = $clog2(MAX_OUTST);
  localparam int CW   = PTRW + 1;

  logic [IDXW-1:0] last_grant;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] tag_mem [MAX_OUTST];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, pop, push, arb_en;
  logic [N_REQ-1:0] grant;

  assign full  = (count == CW'(MAX_OUTST));
  assign empty = (count == '0);
  // A result popping in this cycle frees a slot, so a full FIFO may still grant.
  assign pop    = clk_en && unit_res_val && !empty;
  assign arb_en = clk_en && (!full || pop);

  rr_arb_core #(.N(N_REQ), .PW(IDXW)) u_rr (
    .req   (req_val),
    .ptr   (last_grant),
    .en    (arb_en),
    .grant (grant)
  );

  assign req_rdy = grant;
  assign push    = |grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = IDXW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && push) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unit_op_val <= 1'b0;
      unit_op_a   <= '0;
      unit_op_b   <= '0;
      unit_sel    <= 1'b0;
      rsp_val     <= '0;
      rsp_data    <= '0;
      err_ovf     <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_grant  <= IDXW'(N_REQ - 1);
    end else if (clk_en) begin
      unit_op_val <= push;
      if (push) begin
        unit_op_a  <= req_op_a[grant_idx];
        unit_op_b  <= req_op_b[grant_idx];
        unit_sel   <= req_sel[grant_idx];
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant_idx;
      end
      rsp_val <= '0;
      if (pop) begin
        rsp_data <= unit_res;
        rsp_val  <= {{(N_REQ-1){1'b0}}, 1'b1} << tag_mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (unit_res_val && empty) err_ovf <= 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_arith_share_arb.sv
// Directed bench for arith_share_arb; the bench plays the arithmetic unit.
module tb_arith_share_arb;
  import arith_pckg::*;

  localparam int W = C_ARITH_WORD_LEN;

  logic              clk = 1'b0;
  logic              rst_n, clk_en;
  logic [3:0]        req_val, req_rdy, req_sel, rsp_val;
  logic [3:0][W-1:0] req_op_a, req_op_b;
  logic [W-1:0]      unit_op_a, unit_op_b, unit_res, rsp_data;
  logic              unit_op_val, unit_sel, unit_res_val, err_ovf;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  arith_share_arb #(.N_REQ(4), .MAX_OUTST(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_sel(req_sel),
    .unit_op_a(unit_op_a), .unit_op_b(unit_op_b),
    .unit_op_val(unit_op_val), .unit_sel(unit_sel),
    .unit_res(unit_res), .unit_res_val(unit_res_val),
    .rsp_data(rsp_data), .rsp_val(rsp_val), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; clk_en = 1'b1; req_val = '0; unit_res_val = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    total++; if (unit_op_val !== 1'b0) begin bad++; $display("FAIL reset_op_val got=%b exp=0", unit_op_val); end
    total++; if (rsp_val !== 4'b0) begin bad++; $display("FAIL reset_rsp_val got=%b exp=0000", rsp_val); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_ovf); end
    total++; if (unit_op_a !== '0 || unit_op_b !== '0 || unit_sel !== 1'b0 || rsp_data !== '0) begin
      bad++; $display("FAIL reset_data a=%0d b=%0d sel=%b rsp=%0d exp all 0", unit_op_a, unit_op_b, unit_sel, rsp_data);
    end
    total++; if (req_rdy !== 4'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0000", req_rdy); end
  endtask

  task automatic test_single;
    do_reset;
    req_op_a[0] = 3; req_op_b[0] = 5; req_sel = 4'b0000; req_val = 4'b0001;
    #1;
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL single_rdy got=%b exp=0001", req_rdy); end
    tick;
    req_val = '0;
    total++; if (unit_op_val !== 1'b1 || unit_op_a !== 3 || unit_op_b !== 5 || unit_sel !== 1'b0) begin
      bad++; $display("FAIL single_issue val=%b a=%0d b=%0d sel=%b exp 1/3/5/0", unit_op_val, unit_op_a, unit_op_b, unit_sel);
    end
    tick;
    total++; if (unit_op_val !== 1'b0) begin bad++; $display("FAIL single_issue_drop got=%b exp=0", unit_op_val); end
    tick;
    unit_res = 8; unit_res_val = 1'b1;
    total++; if (rsp_val !== 4'b0) begin bad++; $display("FAIL single_early_rsp got=%b exp=0000", rsp_val); end
    tick;
    unit_res_val = 1'b0;
    total++; if (rsp_val !== 4'b0001 || rsp_data !== 8) begin
      bad++; $display("FAIL single_rsp val=%b data=%0d exp 0001/8", rsp_val, rsp_data);
    end
    tick;
    total++; if (rsp_val !== 4'b0) begin bad++; $display("FAIL single_rsp_drop got=%b exp=0000", rsp_val); end
  endtask

  task automatic test_round_robin;
    int cnt [4];
    logic [1:0] t;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      req_op_a[i] = W'(10 + i); req_op_b[i] = W'(20 + i); cnt[i] = 0;
    end
    req_sel = 4'b1010; req_val = 4'hf;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (req_rdy !== oh(k % 4)) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_rdy, oh(k % 4)); end
      exp_q.push_back(2'(k % 4));
      tick;
      total++; if (unit_op_val !== 1'b1 || unit_op_a !== W'(10 + k % 4) || unit_op_b !== W'(20 + k % 4) || unit_sel !== req_sel[k % 4]) begin
        bad++; $display("FAIL rr_issue k=%0d val=%b a=%0d b=%0d sel=%b", k, unit_op_val, unit_op_a, unit_op_b, unit_sel);
      end
    end
    req_val = '0;
    for (int k = 0; k < 8; k++) begin
      unit_res = W'(100 + k); unit_res_val = 1'b1;
      tick;
      t = exp_q.pop_front();
      cnt[t]++;
      total++; if (rsp_val !== oh(int'(t)) || rsp_data !== W'(100 + k)) begin
        bad++; $display("FAIL rr_rsp k=%0d val=%b data=%0d exp %b/%0d", k, rsp_val, rsp_data, oh(int'(t)), 100 + k);
      end
    end
    unit_res_val = 1'b0;
    tick;
    total++; if (rsp_val !== 4'b0) begin bad++; $display("FAIL rr_rsp_drop got=%b exp=0000", rsp_val); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cnt[i] != 2) begin bad++; $display("FAIL rr_count req=%0d got=%0d exp=2", i, cnt[i]); end
    end
  endtask

  task automatic test_stall;
    do_reset;
    req_val = 4'hf;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (req_rdy !== oh(k % 4)) begin bad++; $display("FAIL stall_grant k=%0d got=%b exp=%b", k, req_rdy, oh(k % 4)); end
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (req_rdy !== 4'b0) begin bad++; $display("FAIL stall_full k=%0d got=%b exp=0000", k, req_rdy); end
      tick;
    end
    unit_res = 55; unit_res_val = 1'b1;
    #1;
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL stall_reopen got=%b exp=0001", req_rdy); end
    tick;
    unit_res_val = 1'b0;
    total++; if (rsp_val !== 4'b0001 || rsp_data !== 55) begin
      bad++; $display("FAIL stall_first_rsp val=%b data=%0d exp 0001/55", rsp_val, rsp_data);
    end
    #1;
    total++; if (req_rdy !== 4'b0) begin bad++; $display("FAIL stall_refull got=%b exp=0000", req_rdy); end
    req_val = '0;
    for (int k = 0; k < 8; k++) begin
      unit_res = W'(200 + k); unit_res_val = 1'b1;
      tick;
      total++; if (rsp_val !== oh((k + 1) % 4) || rsp_data !== W'(200 + k)) begin
        bad++; $display("FAIL stall_drain k=%0d val=%b data=%0d exp %b/%0d", k, rsp_val, rsp_data, oh((k + 1) % 4), 200 + k);
      end
    end
    unit_res_val = 1'b0;
    tick;
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL stall_no_err got=%b exp=0", err_ovf); end
  endtask

  task automatic test_empty_err;
    do_reset;
    req_op_a[1] = 7; req_op_b[1] = 9; req_val = 4'b0010;
    unit_res = 77; unit_res_val = 1'b1;
    #1;
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL empty_push_rdy got=%b exp=0010", req_rdy); end
    tick;
    req_val = '0; unit_res_val = 1'b0;
    total++; if (err_ovf !== 1'b1 || rsp_val !== 4'b0 || unit_op_val !== 1'b1) begin
      bad++; $display("FAIL empty_err err=%b rsp=%b opval=%b exp 1/0000/1", err_ovf, rsp_val, unit_op_val);
    end
    unit_res = 16; unit_res_val = 1'b1;
    tick;
    total++; if (rsp_val !== 4'b0010 || rsp_data !== 16) begin
      bad++; $display("FAIL empty_kept_tag val=%b data=%0d exp 0010/16", rsp_val, rsp_data);
    end
    unit_res = 99;
    tick;
    unit_res_val = 1'b0;
    total++; if (rsp_val !== 4'b0 || err_ovf !== 1'b1 || rsp_data !== 16) begin
      bad++; $display("FAIL empty_second val=%b err=%b data=%0d exp 0000/1/16", rsp_val, err_ovf, rsp_data);
    end
    tick;
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL empty_sticky got=%b exp=1", err_ovf); end
  endtask

  task automatic test_clk_en;
    do_reset;
    for (int i = 0; i < 4; i++) begin req_op_a[i] = W'(10 + i); req_op_b[i] = W'(20 + i); end
    req_val = 4'hf;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(2'(k));
      tick;
    end
    clk_en = 1'b0; unit_res = 123; unit_res_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_rdy !== 4'b0) begin bad++; $display("FAIL gate_rdy k=%0d got=%b exp=0000", k, req_rdy); end
      tick;
      total++; if (unit_op_val !== 1'b1 || unit_op_a !== 11 || rsp_val !== 4'b0 || err_ovf !== 1'b0) begin
        bad++; $display("FAIL gate_hold k=%0d opval=%b a=%0d rsp=%b err=%b", k, unit_op_val, unit_op_a, rsp_val, err_ovf);
      end
    end
    clk_en = 1'b1; unit_res_val = 1'b0;
    for (int k = 2; k < 4; k++) begin
      #1;
      total++; if (req_rdy !== oh(k)) begin bad++; $display("FAIL gate_resume k=%0d got=%b exp=%b", k, req_rdy, oh(k)); end
      exp_q.push_back(2'(k));
      tick;
    end
    req_val = '0;
    for (int k = 0; k < 4; k++) begin
      unit_res = W'(300 + k); unit_res_val = 1'b1;
      tick;
      total++; if (rsp_val !== oh(int'(exp_q[0])) || rsp_data !== W'(300 + k)) begin
        bad++; $display("FAIL gate_rsp k=%0d val=%b data=%0d exp %b/%0d", k, rsp_val, rsp_data, oh(int'(exp_q[0])), 300 + k);
      end
      void'(exp_q.pop_front());
    end
    unit_res_val = 1'b0;
    tick;
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL gate_no_err got=%b exp=0", err_ovf); end
  endtask

  task automatic test_reset_outstanding;
    do_reset;
    for (int i = 0; i < 4; i++) begin req_op_a[i] = W'(40 + i); req_op_b[i] = W'(50 + i); end
    req_sel = 4'hf; req_val = 4'hf;
    for (int k = 0; k < 5; k++) tick;
    req_val = '0; rst_n = 1'b0; clk_en = 1'b0;
    tick;
    rst_n = 1'b1; clk_en = 1'b1;
    total++; if (unit_op_val !== 1'b0 || unit_op_a !== '0 || unit_op_b !== '0 || unit_sel !== 1'b0 ||
                 rsp_val !== 4'b0 || rsp_data !== '0 || err_ovf !== 1'b0) begin
      bad++; $display("FAIL rst_out opval=%b a=%0d b=%0d sel=%b rsp=%b data=%0d err=%b exp all 0",
                      unit_op_val, unit_op_a, unit_op_b, unit_sel, rsp_val, rsp_data, err_ovf);
    end
    req_val = 4'hf;
    #1;
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b exp=0001", req_rdy); end
    req_val = '0;
    #1;
    for (int k = 0; k < 5; k++) begin
      unit_res = W'(k); unit_res_val = 1'b1;
      tick;
      total++; if (err_ovf !== 1'b1 || rsp_val !== 4'b0) begin
        bad++; $display("FAIL rst_stale k=%0d err=%b rsp=%b exp 1/0000", k, err_ovf, rsp_val);
      end
    end
    unit_res_val = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; req_val = '0; req_sel = '0;
    req_op_a = '0; req_op_b = '0; unit_res = '0; unit_res_val = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_empty_err;
    test_clk_en;
    test_reset_outstanding;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
